// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider with valid/ready handshakes (WIDTH/WIDTH, one quotient bit per clock)
//   Ports: clk, rst_n (async active-low); in_valid/in_ready + dividend/divisor operand channel;
//          out_valid/out_ready + quotient/remainder/div_by_zero result channel.
//   Optional: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating quotient,
//          remainder takes the dividend's sign); default build is unsigned.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dsr;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff, rem_nx, quo_nx, a_mag, b_mag, q_fix, r_fix;
  logic             take;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_q, neg_r;
`endif
  // quo doubles as the dividend shift register: its MSB feeds the partial remainder
  // while quotient bits enter at the LSB.
  always_comb begin
    sh     = {rem, quo[WIDTH-1]};
    take   = sh >= {1'b0, dsr};
    diff   = sh[WIDTH-1:0] - dsr;
    rem_nx = take ? diff : sh[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], take};
`ifdef SEQ_DIVIDER_SIGNED_EN
    a_mag  = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag  = divisor[WIDTH-1] ? -divisor : divisor;
    q_fix  = neg_q ? -quo_nx : quo_nx;
    r_fix  = neg_r ? -rem_nx : rem_nx;
`else
    a_mag  = dividend;
    b_mag  = divisor;
    q_fix  = quo_nx;
    r_fix  = rem_nx;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dsr         <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          quo      <= a_mag;
          dsr      <= b_mag;
          rem      <= '0;
          cnt      <= CW'(WIDTH);
          state    <= BUSY;
          in_ready <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
          neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r    <= dividend[WIDTH-1];
`endif
        end
        BUSY: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          // A zero divisor makes every trial subtract succeed, so the core alone
          // already leaves the dividend magnitude as remainder; only the quotient
          // needs forcing (the signed fix-up would otherwise flip it).
          if (cnt == CW'(1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= (dsr == '0) ? '1 : q_fix;
            remainder   <= r_fix;
            div_by_zero <= dsr == '0;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven, hand-sequenced and randomized checks of seq_divider against an arithmetic model
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        in_ready, out_valid, div_by_zero;
  logic [15:0] quotient, remainder;
  int          n_chk = 0, n_fail = 0;

  seq_divider #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        dz;
    int          hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model(input logic [15:0] a, b, output logic [15:0] q, r, output logic dz);
    dz = (b == 0);
`ifdef SEQ_DIVIDER_SIGNED_EN
    begin
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = dz ? 16'hFFFF : 16'(sa / sb);
      r  = dz ? a : 16'(sa % sb);
    end
`else
    q = dz ? 16'hFFFF : a / b;
    r = dz ? a : a % b;
`endif
  endtask

  // Issue one operand pair from a negedge, wait for the result, apply `hold` cycles of
  // backpressure, then release it. Expected values come from the table or the model.
  task automatic op(input logic [15:0] a, b, eq, er, input logic ed, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_before_issue", in_ready, 1);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    in_valid = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      chk("in_ready_low_busy", in_ready, 0);
      @(negedge clk); n++;
    end
    chk("latency", n, 16);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ed);
    chk("in_ready_vs_out_valid", in_ready, 0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("persist_quotient", quotient, eq);
  endtask

  initial begin
    vec_t vt[$];
    logic [15:0] eq, er;
    logic ed;
    time t1, t2;
    int n;
`ifdef SEQ_DIVIDER_SIGNED_EN
    vt.push_back('{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 0});
    vt.push_back('{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 0});
    vt.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 0});
    vt.push_back('{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 0});
    vt.push_back('{16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1, 2});
    vt.push_back('{16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 0});
`else
    vt.push_back('{16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 0});
    vt.push_back('{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 0});
    vt.push_back('{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 5});
    vt.push_back('{16'd3, 16'd9, 16'd0, 16'd3, 1'b0, 0});
    vt.push_back('{16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 1});
    vt.push_back('{16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 0});
`endif
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dz", div_by_zero, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    foreach (vt[i]) op(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, vt[i].hold);

    // Reset in the middle of a division aborts it and clears the outputs at once.
    in_valid = 1'b1; dividend = 16'h1000; divisor = 16'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_result", out_valid, 0);
    op(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 0);

    // Back-to-back with out_ready held high: results 18 cycles apart.
    out_ready = 1'b1;
    in_valid = 1'b1; dividend = 16'd65535; divisor = 16'd256;
    @(negedge clk);
    dividend = 16'd3; divisor = 16'd9;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    t1 = $time;
    model(16'd65535, 16'd256, eq, er, ed);
    chk("b2b1_quotient", quotient, 16'd255);
    chk("b2b1_remainder", remainder, 16'd255);
    chk("b2b1_model_q", quotient, eq);
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    t2 = $time;
    in_valid = 1'b0;
    chk("b2b2_quotient", quotient, 16'd0);
    chk("b2b2_remainder", remainder, 16'd3);
    chk("b2b_spacing", 32'((t2 - t1) / 10), 18);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", in_ready, 1);

    // Randomized operands and backpressure against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      logic [15:0] a, b;
      int sel;
      sel = int'($urandom_range(0, 9));
      a = 16'($urandom);
      b = (sel == 0) ? 16'h0 : (sel < 4) ? 16'($urandom_range(1, 15)) : 16'($urandom);
      model(a, b, eq, er, ed);
      op(a, b, eq, er, ed, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider, WIDTH/WIDTH bits, one quotient bit per clock.
- Inverse companion to the registered multiplier designs used in our DSP-mapping flow.
- Serves as a multi-cycle, handshake-driven target for the sequential-equivalence and initiation-interval tooling.
- Sits between a valid/ready producer of operand pairs and a valid/ready consumer of quotient/remainder results.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  divider can accept operands.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  result held valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  result came from a zero divisor; qualified by out_valid.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Reset asserted mid-division aborts the operation; no result is produced.
- FSM IDLE:
  - in_ready=1.
  - in_valid=1 at a rising edge accepts the operands: latches them, clears the partial remainder, loads counter=WIDTH, goes to BUSY.
  - in_valid=0: stays in IDLE.
- FSM BUSY:
  - in_ready=0.
  - Each cycle: shift {partial remainder, dividend} left by 1; trial-subtract the divisor from the WIDTH+1-bit partial remainder.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter decrements each cycle. The edge on which counter reaches 0 moves to DONE and registers quotient, remainder and div_by_zero.
- FSM DONE:
  - out_valid=1; outputs stay stable while out_ready=0.
  - out_ready=1 at an edge returns to IDLE with out_valid=0. No skid buffer.
  - The next operand pair is accepted only from IDLE, one cycle later.
- Latency: operands accepted at edge T → out_valid high after edge T+WIDTH (WIDTH+1 clock periods including the accept cycle). Fixed for every operand pair, including divide-by-zero.
- Throughput: one result per WIDTH+2 cycles when out_ready is held high.
- Arithmetic (unsigned default):
  - quotient=floor(dividend/divisor), remainder=dividend mod divisor.
  - Invariant: dividend == quotient*divisor + remainder and remainder < divisor whenever divisor != 0.
- Divide-by-zero: quotient=all ones, remainder=dividend, div_by_zero=1, same fixed latency.
- Output registers persist until the next DONE entry; they are not cleared on return to IDLE.
- Operand inputs are ignored outside the IDLE accept edge; changes during BUSY have no effect.
- in_ready and out_valid are never high together.

Optional Feature:
- Macro SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Operands and results are two's complement.
  - Magnitudes are divided by the unsigned core.
  - Quotient truncates toward zero and is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Overflow case: most-negative dividend / −1 → quotient=most-negative, remainder=0, div_by_zero=0.
  - Divide-by-zero: quotient=all ones (−1), remainder=dividend.
  - Sign fix-up is registered at the DONE transition; latency is unchanged.
- Undefined: unsigned only, as described above.

Test Plan:
- Reset then idle (WIDTH=16): check in_ready=1, out_valid=0, outputs 0. Drive dividend=1000, divisor=7 with in_valid=1 at edge T → out_valid rises after edge T+16 with quotient=142, remainder=6, div_by_zero=0.
- Divisor=0, dividend=0x1234 → after 16 cycles: quotient=0xFFFF, remainder=0x1234, div_by_zero=1.
- Backpressure: 0xFFFF/0x0001 with out_ready=0 for 5 cycles → quotient=0xFFFF, remainder=0 held stable, in_ready=0 throughout. Raise out_ready → next cycle out_valid=0, in_ready=1.
- Reset mid-operation: assert rst_n=0 at BUSY cycle 8 → outputs immediately at reset values. After release, 50/5 completes with quotient=10, remainder=0.
- Back-to-back with out_ready=1: 65535/256 then 3/9 → quotient=255, remainder=255; then quotient=0, remainder=3. Results spaced exactly 18 cycles apart.
- SEQ_DIVIDER_SIGNED_EN defined:
  - −7/2 → quotient=−3, remainder=−1.
  - 7/−2 → quotient=−3, remainder=1.
  - 0x8000/0xFFFF → quotient=0x8000, remainder=0.
